// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data-SRAM responder: byte-lane word memory, registered read, wait-state stall
// Optional misalignment flag built only when SRAM_ALIGN_CHECK_EN is defined.
module data_sram_resp #(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq,
  output logic        misalign_err
);

  localparam int DEPTH       = 1 << ADDR_WIDTH;
  localparam int CNT_INIT_I  = (WAIT_CYCLES > 0) ? (WAIT_CYCLES - 1) : 0;
  localparam logic [3:0] CNT_INIT = CNT_INIT_I[3:0];

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state, next_state;
  logic [3:0]      cnt, next_cnt;
  logic            stall, commit, fire;
  logic [ADDR_WIDTH-1:0] idx;
  logic [31:0]     mem [DEPTH];

  assign idx = data_sram_addr[ADDR_WIDTH+1:2];

  // Upper address bits alias the array; low bits never select a word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{data_sram_addr[31:ADDR_WIDTH+2], data_sram_addr[1:0]};

  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    stall      = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE: begin
        if (data_sram_en) begin
          if (WAIT_CYCLES == 0) begin
            commit = 1'b1;
          end else begin
            stall      = 1'b1;
            next_cnt   = CNT_INIT;
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (!data_sram_en) begin
          next_state = IDLE;
          next_cnt   = 4'd0;
        end else if (cnt != 4'd0) begin
          stall    = 1'b1;
          next_cnt = cnt - 4'd1;
        end else begin
          commit     = 1'b1;
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  assign fire     = commit && !rst;
  assign stallreq = stall && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_ff @(posedge clk) begin
    if (fire) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) begin
          mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Read data only moves on a committed read; writes and idle cycles leave it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_sram_rdata <= 32'd0;
    end else if (fire && (data_sram_wen == 4'b0000)) begin
      data_sram_rdata <= mem[idx];
    end
  end

`ifdef SRAM_ALIGN_CHECK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (fire && ((data_sram_wen == 4'b0000) || (data_sram_wen == 4'b1111))
                 && (data_sram_addr[1:0] != 2'b00)) begin
      err_q <= 1'b1;
    end
  end
  assign misalign_err = err_q;
`else
  assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - randomized bench for data_sram_resp against a transaction-level model
// Two instances: WAIT_CYCLES=0/ADDR_WIDTH=12 and WAIT_CYCLES=3/ADDR_WIDTH=4.
module tb_data_sram_resp;

  logic        clk;
  logic [1:0]  rst, en;
  logic [3:0]  wen   [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1, err0, err1;

  int tests = 0;
  int fails = 0;

  data_sram_resp #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
    .data_sram_addr(addr[0]), .data_sram_wdata(wdata[0]),
    .data_sram_rdata(rdata0), .stallreq(stall0), .misalign_err(err0));

  data_sram_resp #(.ADDR_WIDTH(4), .WAIT_CYCLES(3)) u_dut1 (
    .clk(clk), .rst(rst[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
    .data_sram_addr(addr[1]), .data_sram_wdata(wdata[1]),
    .data_sram_rdata(rdata1), .stallreq(stall1), .misalign_err(err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a held request is serviced once it has been seen for N cycles.
  int          m_n   [2] = '{0, 3};
  int          m_aw  [2] = '{12, 4};
  int          m_age [2] = '{0, 0};
  logic [31:0] m_rdata [2];
  bit          m_rknown [2] = '{0, 0};
  bit          m_err  [2] = '{0, 0};
  bit          m_commit [2] = '{0, 0};
  bit          s_stall [2] = '{0, 0};
  logic [31:0] m_mem [int];
  logic [3:0]  m_bv  [int];

  function automatic logic [31:0] rd(int k);
    return (k == 0) ? rdata0 : rdata1;
  endfunction
  function automatic logic st(int k);
    return (k == 0) ? stall0 : stall1;
  endfunction
  function automatic logic er(int k);
    return (k == 0) ? err0 : err1;
  endfunction

  task automatic chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s inst=%0d t=%0t actual=%h required=%h", name, k, $time, act, exp);
    end
  endtask

  task automatic model_commit(int k);
    int key;
    key = k * 65536 + (int'(addr[k] >> 2) & ((1 << m_aw[k]) - 1));
    if (wen[k] == 4'b0000) begin
      if (m_bv.exists(key) && m_bv[key] == 4'hF) begin
        m_rdata[k]  = m_mem[key];
        m_rknown[k] = 1;
      end else begin
        m_rknown[k] = 0;
      end
    end else begin
      if (!m_bv.exists(key)) begin
        m_mem[key] = 32'd0;
        m_bv[key]  = 4'h0;
      end
      for (int b = 0; b < 4; b++) begin
        if (wen[k][b]) begin
          m_mem[key][8*b +: 8] = wdata[k][8*b +: 8];
          m_bv[key][b] = 1'b1;
        end
      end
    end
`ifdef SRAM_ALIGN_CHECK_EN
    if ((wen[k] == 4'b0000 || wen[k] == 4'b1111) && addr[k][1:0] != 2'b00) m_err[k] = 1;
`endif
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      m_commit[k] = 0;
      if (rst[k]) begin
        m_age[k] = 0; m_rdata[k] = 32'd0; m_rknown[k] = 1; m_err[k] = 0;
      end else if (en[k]) begin
        if (m_age[k] == m_n[k]) begin
          model_commit(k);
          m_commit[k] = 1;
          m_age[k] = 0;
        end else begin
          m_age[k]++;
        end
      end else begin
        m_age[k] = 0;
      end
    end
  endtask

  task automatic compare();
    for (int k = 0; k < 2; k++) begin
      s_stall[k] = st(k);
      if (!rst[k]) begin
        if (m_rknown[k]) chk("rdata", k, rd(k), m_rdata[k]);
        if (en[k] || m_age[k] == 0)
          chk("stallreq", k, {31'd0, st(k)},
              {31'd0, (m_n[k] > 0 && en[k] && m_age[k] < m_n[k])});
        chk("misalign_err", k, {31'd0, er(k)}, {31'd0, m_err[k]});
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic access(int k, logic [3:0] w, logic [31:0] a, logic [31:0] d,
                        output int stalls, output int cycles);
    bit done;
    done = 0; stalls = 0; cycles = 0;
    en[k] = 1'b1; wen[k] = w; addr[k] = a; wdata[k] = d;
    for (int c = 0; c < 20 && !done; c++) begin
      tick();
      cycles++;
      if (s_stall[k]) stalls++;
      if (m_commit[k]) done = 1;
    end
    if (!done) chk("access_timeout", k, 32'd0, 32'd1);
    en[k] = 1'b0;
  endtask

  int s, c;

  initial begin
    rst = 2'b11; en = 2'b00;
    for (int k = 0; k < 2; k++) begin
      wen[k] = 4'd0; addr[k] = 32'd0; wdata[k] = 32'd0;
    end
    tick(); tick();
    rst = 2'b00;
    for (int k = 0; k < 2; k++) begin
      chk("reset_rdata", k, rd(k), 32'd0);
      chk("reset_stall", k, {31'd0, st(k)}, 32'd0);
      chk("reset_err", k, {31'd0, er(k)}, 32'd0);
    end

    access(0, 4'hF, 32'h10, 32'hDEADBEEF, s, c);
    access(0, 4'h0, 32'h10, 32'h0, s, c);
    chk("rd_after_wr", 0, rdata0, 32'hDEADBEEF);
    chk("no_stall_n0", 0, s, 0);
    chk("latency_n0", 0, c, 1);

    access(0, 4'hF, 32'h20, 32'h11223344, s, c);
    access(0, 4'h5, 32'h20, 32'hAABBCCDD, s, c);
    access(0, 4'h0, 32'h20, 32'h0, s, c);
    chk("byte_lanes", 0, rdata0, 32'h11BB33DD);

    access(0, 4'hF, 32'h4000, 32'h5A5A5A5A, s, c);
    access(0, 4'h0, 32'h0, 32'h0, s, c);
    chk("wrap", 0, rdata0, 32'h5A5A5A5A);

    access(1, 4'hF, 32'h8, 32'hCAFEF00D, s, c);
    chk("wr_stalls_n3", 1, s, 3);
    access(1, 4'h0, 32'h8, 32'h0, s, c);
    chk("rd_stalls_n3", 1, s, 3);
    chk("rd_cycles_n3", 1, c, 4);
    chk("rd_data_n3", 1, rdata1, 32'hCAFEF00D);
    access(1, 4'h0, 32'h8, 32'h0, s, c);
    chk("b2b_stalls_n3", 1, s, 3);
    chk("b2b_cycles_n3", 1, c, 4);

    access(1, 4'hF, 32'h30, 32'h0, s, c);
    en[1] = 1'b1; wen[1] = 4'hF; addr[1] = 32'h30; wdata[1] = 32'h12345678;
    tick();
    rst[1] = 1'b1; en[1] = 1'b0;
    tick();
    rst[1] = 1'b0;
    chk("abort_stall", 1, {31'd0, stall1}, 32'd0);
    chk("abort_rdata", 1, rdata1, 32'd0);
    access(1, 4'h0, 32'h30, 32'h0, s, c);
    chk("abort_nocommit", 1, rdata1, 32'd0);

    access(0, 4'h0, 32'h22, 32'h0, s, c);
    chk("misalign_rd_data", 0, rdata0, 32'h11BB33DD);
`ifdef SRAM_ALIGN_CHECK_EN
    chk("misalign_set", 0, {31'd0, err0}, 32'd1);
    access(0, 4'h0, 32'h20, 32'h0, s, c);
    chk("misalign_sticky", 0, {31'd0, err0}, 32'd1);
`else
    chk("misalign_off", 0, {31'd0, err0}, 32'd0);
`endif

    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (rst[k]) begin
          rst[k] = 1'b0;
        end else if ($urandom_range(0, 299) == 0) begin
          rst[k] = 1'b1;
        end
        if (en[k] && m_age[k] != 0) begin
          if ($urandom_range(0, 19) == 0) en[k] = 1'b0;
        end else begin
          en[k] = ($urandom_range(0, 9) < 7);
          case ($urandom_range(0, 3))
            0, 1:    wen[k] = 4'h0;
            2:       wen[k] = 4'hF;
            default: wen[k] = 4'($urandom_range(0, 15));
          endcase
          addr[k]  = (32'($urandom_range(0, 3)) << (m_aw[k] + 2))
                   | (32'($urandom_range(0, 15)) << 2)
                   | 32'($urandom_range(0, 3));
          wdata[k] = $urandom;
        end
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
